game_cfg_loader: RTL and testbench

Captures the game selection for the board from the HPS/ioctl download stream and presents it as a registered `game_t` value to the board-configuration logic and the rest of the core. Sits between the ioctl download port and every consumer of `game`, parsing a short fixed-format configuration record, validating it, and committing the result atomically at the end of the download. It is the writer side of the game-selection path; board configuration decode only ever reads its `game` output.

---
 rtl/game_cfg_loader.sv | 169 ++++++++++++++++
 tb/tb_game_cfg_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/game_cfg_loader.sv
// game_cfg_loader: parses the game-selection record from the ioctl download
// stream and commits the game ID atomically once the download ends.
// Record: addr 0 = 0x54, addr 1 = 0x46, addr 2 = game ID, addr 3 = flags (0x00),
// addr 4 = checksum (XOR of bytes 0..3).
// Optional feature macro: GAME_CFG_CHECKSUM_EN -- when defined the checksum byte
// is required and verified; otherwise a 4-byte record is complete.
//
// state   | meaning
// IDLE    | waiting for a download on CFG_INDEX
// RECV    | capturing record bytes into shadow registers
// CHECK   | one-cycle validation of the captured record
// COMMIT  | publish shadow ID to game, pulse game_update
// REJECT  | flag cfg_error, keep previous game

package game_cfg_pkg;
  typedef logic [7:0] game_t;
endpackage

module game_cfg_loader
  import game_cfg_pkg::*;
#(
  parameter logic [7:0] CFG_INDEX   = 8'd2,
  parameter logic [7:0] MAX_GAME_ID = 8'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output game_t       game,
  output logic        game_valid,
  output logic        game_update,
  output logic        cfg_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RECV   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_REJECT = 3'd4;

  localparam logic [7:0] MAGIC0 = 8'h54;
  localparam logic [7:0] MAGIC1 = 8'h46;

`ifdef GAME_CFG_CHECKSUM_EN
  localparam logic [26:0] REC_LEN   = 27'd5;
  localparam logic [4:0]  MASK_FULL = 5'b11111;
`else
  localparam logic [26:0] REC_LEN   = 27'd4;
  localparam logic [4:0]  MASK_FULL = 5'b01111;
`endif

  logic [2:0] state;
  logic [4:0] mask;
  logic       dup;
  logic       bad;
  logic [7:0] sh_magic0;
  logic [7:0] sh_magic1;
  logic [7:0] sh_id;
  logic [7:0] sh_flags;
`ifdef GAME_CFG_CHECKSUM_EN
  logic [7:0] sh_csum;
`endif

  logic       cfg_sel;
  logic       addr_ok;
  logic [2:0] byte_sel;
  logic [4:0] sel_onehot;
  logic       accept;

  // Decode the current write: which record byte it targets, if any.
  always_comb begin
    cfg_sel    = (ioctl_index == CFG_INDEX);
    addr_ok    = (ioctl_addr < REC_LEN);
    byte_sel   = ioctl_addr[2:0];
    sel_onehot = 5'b00001 << byte_sel;
  end

  // Record validation, evaluated while in CHECK.
  always_comb begin
    accept = (mask == MASK_FULL) && !dup && !bad &&
             (sh_magic0 == MAGIC0) && (sh_magic1 == MAGIC1) &&
             (sh_flags == 8'h00) && (sh_id <= MAX_GAME_ID);
`ifdef GAME_CFG_CHECKSUM_EN
    if (sh_csum != (sh_magic0 ^ sh_magic1 ^ sh_id ^ sh_flags))
      accept = 1'b0;
`endif
  end

  // Loader FSM, shadow capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mask        <= '0;
      dup         <= 1'b0;
      bad         <= 1'b0;
      sh_magic0   <= '0;
      sh_magic1   <= '0;
      sh_id       <= '0;
      sh_flags    <= '0;
`ifdef GAME_CFG_CHECKSUM_EN
      sh_csum     <= '0;
`endif
      game        <= '0;
      game_valid  <= 1'b0;
      game_update <= 1'b0;
      cfg_error   <= 1'b0;
    end else begin
      game_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ioctl_download && cfg_sel) begin
            state     <= S_RECV;
            mask      <= '0;
            dup       <= 1'b0;
            bad       <= 1'b0;
            sh_magic0 <= '0;
            sh_magic1 <= '0;
            sh_id     <= '0;
            sh_flags  <= '0;
`ifdef GAME_CFG_CHECKSUM_EN
            sh_csum   <= '0;
`endif
          end
        end
        S_RECV: begin
          if (ioctl_download && !cfg_sel)
            bad <= 1'b1;
          // A write coincident with the download fall is still captured.
          if (ioctl_wr && cfg_sel && addr_ok) begin
            if ((mask & sel_onehot) != 5'b00000)
              dup <= 1'b1;
            mask <= mask | sel_onehot;
            case (byte_sel)
              3'd0: sh_magic0 <= ioctl_dout;
              3'd1: sh_magic1 <= ioctl_dout;
              3'd2: sh_id     <= ioctl_dout;
              3'd3: sh_flags  <= ioctl_dout;
`ifdef GAME_CFG_CHECKSUM_EN
              3'd4: sh_csum   <= ioctl_dout;
`endif
              default: ;
            endcase
          end
          if (!ioctl_download)
            state <= S_CHECK;
        end
        S_CHECK: begin
          state <= accept ? S_COMMIT : S_REJECT;
        end
        S_COMMIT: begin
          game        <= sh_id;
          game_valid  <= 1'b1;
          game_update <= 1'b1;
          cfg_error   <= 1'b0;
          state       <= S_IDLE;
        end
        S_REJECT: begin
          cfg_error <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_cfg_loader.sv
// Directed bench for game_cfg_loader; expectations adapt to GAME_CFG_CHECKSUM_EN.
module tb_game_cfg_loader;
  import game_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  game_t       game;
  logic        game_valid;
  logic        game_update;
  logic        cfg_error;

  int checks = 0;
  int errors = 0;

  game_cfg_loader #(.CFG_INDEX(8'd2), .MAX_GAME_ID(8'd31)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .game(game), .game_valid(game_valid), .game_update(game_update),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

`ifdef GAME_CFG_CHECKSUM_EN
  localparam logic [7:0] CS5 = 8'h17;
  localparam bit CSUM_ON = 1'b1;
`else
  localparam logic [7:0] CS5 = 8'h0F;
  localparam bit CSUM_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    tick();
  endtask

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  // rec holds byte 0 in bits 39:32; last write coincides with the download fall
  task automatic send_record(input logic [7:0] idx, input logic [39:0] rec, input int n);
    start_dl(idx);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) ioctl_download = 1'b0;
      wr_byte(27'(i), rec[39-8*i -: 8]);
    end
  endtask

  // Called right after the edge that sampled the download fall.
  task automatic expect_result(input string tag, input logic [7:0] prev_game,
                               input logic upd, input logic [7:0] g,
                               input logic v, input logic e);
    tick();
    check({tag, ":check_upd"},  game_update, 1'b0);
    check({tag, ":check_game"}, game, prev_game);
    tick();
    check({tag, ":upd"},   game_update, upd);
    check({tag, ":game"},  game, g);
    check({tag, ":valid"}, game_valid, v);
    check({tag, ":err"},   cfg_error, e);
    tick();
    check({tag, ":upd_low"}, game_update, 1'b0);
  endtask

  initial begin
    do_reset();
    check("rst:game", game, 8'd0);
    check("rst:valid", game_valid, 1'b0);
    check("rst:upd", game_update, 1'b0);
    check("rst:err", cfg_error, 1'b0);

    send_record(8'd2, {8'h54, 8'h46, 8'h05, 8'h00, CS5}, 5);
    expect_result("id5", 8'd0, 1'b1, 8'd5, 1'b1, 1'b0);

    do_reset();
    send_record(8'd2, {8'h54, 8'h46, 8'h05, 8'h00, 8'h00}, 5);
    if (CSUM_ON) expect_result("cs0", 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    else         expect_result("cs0", 8'd0, 1'b1, 8'd5, 1'b1, 1'b0);

    do_reset();
    send_record(8'd2, {8'h54, 8'h46, 8'h05, 8'h00, 8'h17}, 5);
    expect_result("id5b", 8'd0, 1'b1, 8'd5, 1'b1, 1'b0);
    send_record(8'd2, {8'h54, 8'h46, 8'h28, 8'h00, 8'h3A}, 5);
    expect_result("id40", 8'd5, 1'b0, 8'd5, 1'b1, 1'b1);

    send_record(8'd2, {8'h54, 8'h46, 8'h1F, 8'h00, 8'h0D}, 5);
    expect_result("id31", 8'd5, 1'b1, 8'd31, 1'b1, 1'b0);
    send_record(8'd2, {8'h54, 8'h46, 8'h20, 8'h00, 8'h32}, 5);
    expect_result("id32", 8'd31, 1'b0, 8'd31, 1'b1, 1'b1);

    send_record(8'd2, {8'h54, 8'h46, 8'h07, 8'h00, 8'h15}, 5);
    expect_result("id7", 8'd31, 1'b1, 8'd7, 1'b1, 1'b0);
    send_record(8'd2, {8'h54, 8'h46, 8'h08, 8'h00, 8'h1A}, 3);
    expect_result("short", 8'd7, 1'b0, 8'd7, 1'b1, 1'b1);

    send_record(8'd2, {8'h54, 8'h46, 8'h08, 8'h00, 8'h1A}, 5);
    expect_result("id8", 8'd7, 1'b1, 8'd8, 1'b1, 1'b0);
    start_dl(8'd2);
    wr_byte(27'd0, 8'h54);
    wr_byte(27'd1, 8'h46);
    wr_byte(27'd1, 8'h46);
    wr_byte(27'd2, 8'h05);
    wr_byte(27'd3, 8'h00);
    wr_byte(27'd4, 8'h17);
    end_dl();
    expect_result("dup", 8'd8, 1'b0, 8'd8, 1'b1, 1'b1);

    send_record(8'd2, {8'h54, 8'h46, 8'h09, 8'h00, 8'h1B}, 5);
    expect_result("id9", 8'd8, 1'b1, 8'd9, 1'b1, 1'b0);
    start_dl(8'd2);
    wr_byte(27'd0, 8'h54);
    wr_byte(27'd1, 8'h46);
    ioctl_index = 8'd0;
    tick();
    ioctl_index = 8'd2;
    wr_byte(27'd2, 8'h05);
    wr_byte(27'd3, 8'h00);
    wr_byte(27'd4, 8'h17);
    end_dl();
    expect_result("idxchg", 8'd9, 1'b0, 8'd9, 1'b1, 1'b1);

    start_dl(8'd0);
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: wr_byte(27'(i), 8'h54);
        1: wr_byte(27'(i), 8'h46);
        2: wr_byte(27'(i), 8'h03);
        3: wr_byte(27'(i), 8'h00);
        4: wr_byte(27'(i), 8'h11);
        default: wr_byte(27'(i), 8'hAA);
      endcase
      check("idx0:upd", game_update, 1'b0);
    end
    end_dl();
    for (int i = 0; i < 4; i++) begin
      check("idx0:upd_after", game_update, 1'b0);
      tick();
    end
    check("idx0:game", game, 8'd9);
    check("idx0:valid", game_valid, 1'b1);
    check("idx0:err", cfg_error, 1'b1);

    send_record(8'd2, {8'h54, 8'h46, 8'h06, 8'h00, 8'h00}, 4);
    if (CSUM_ON) expect_result("four", 8'd9, 1'b0, 8'd9, 1'b1, 1'b1);
    else         expect_result("four", 8'd9, 1'b1, 8'd6, 1'b1, 1'b0);

    start_dl(8'd2);
    wr_byte(27'd0, 8'h54);
    wr_byte(27'd1, 8'h46);
    wr_byte(27'd2, 8'h05);
    wr_byte(27'd3, 8'h00);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check("rstmid:game", game, 8'd0);
    check("rstmid:valid", game_valid, 1'b0);
    check("rstmid:upd", game_update, 1'b0);
    check("rstmid:err", cfg_error, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    check("rstmid:upd2", game_update, 1'b0);
    check("rstmid:game2", game, 8'd0);
    send_record(8'd2, {8'h54, 8'h46, 8'h02, 8'h00, 8'h10}, 5);
    expect_result("id2", 8'd0, 1'b1, 8'd2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
